// File: rtl/clock_divider_prog.sv
// ---------------------------------------------------------------------------
// clock_divider_prog
//   Programmable integer clock divider. Produces a registered divided clock
//   whose period is R clk_in cycles: floor(R/2) cycles high followed by
//   R - floor(R/2) cycles low, so odd ratios carry the extra cycle in the
//   low phase. The ratio is captured only when a new period starts, so the
//   current period is never disturbed by changes on div_ratio.
//
// Ports
//   clk_in     in   single clock, all logic on its rising edge
//   rst        in   synchronous active-high reset
//   en         in   run enable; dropping it lets the current period finish
//   div_ratio  in   requested ratio N (values below 2 behave as 2)
//   clk_out    out  registered divided clock
//   tick       out  one-cycle pulse in each cycle where clk_out rises
//   active     out  high while a period is in progress
//
// State table
//   state  | meaning
//   IDLE   | stopped, clk_out low, waiting for en
//   HIGH   | high phase of the period, clk_out high
//   LOW    | low phase of the period, clk_out low; period ends here
// ---------------------------------------------------------------------------
module clock_divider_prog #(
    parameter int DIV_WIDTH     = 8,
    parameter int DEFAULT_RATIO = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div_ratio,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 active
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_ratio;
    logic                 r_clk_out;
    logic                 r_tick;
    logic                 r_active;

    logic [DIV_WIDTH-1:0] w_eff_ratio;
    logic [DIV_WIDTH-1:0] w_high_len;
    logic [DIV_WIDTH-1:0] w_low_len;
    logic                 w_high_done;
    logic                 w_low_done;

    // Ratios 0 and 1 cannot form a high and a low phase; treat them as 2.
    assign w_eff_ratio = (div_ratio < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_ratio;

    // R >= 2 always, so both phase lengths are at least 1 and the "-1"
    // terminal compares below cannot underflow. The low phase is the longer
    // one and still fits in DIV_WIDTH bits for R = 2^DIV_WIDTH-1.
    assign w_high_len  = r_ratio >> 1;
    assign w_low_len   = r_ratio - w_high_len;
    assign w_high_done = (r_cnt == w_high_len - DIV_WIDTH'(1));
    assign w_low_done  = (r_cnt == w_low_len - DIV_WIDTH'(1));

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ratio   <= DIV_WIDTH'(DEFAULT_RATIO);
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (en) begin
                        r_state   <= ST_HIGH;
                        r_ratio   <= w_eff_ratio;
                        r_clk_out <= 1'b1;
                        r_tick    <= 1'b1;
                        r_active  <= 1'b1;
                    end else begin
                        r_clk_out <= 1'b0;
                        r_tick    <= 1'b0;
                        r_active  <= 1'b0;
                    end
                end

                ST_HIGH: begin
                    r_tick   <= 1'b0;
                    r_active <= 1'b1;
                    if (w_high_done) begin
                        r_state   <= ST_LOW;
                        r_cnt     <= '0;
                        r_clk_out <= 1'b0;
                    end else begin
                        r_cnt     <= r_cnt + DIV_WIDTH'(1);
                        r_clk_out <= 1'b1;
                    end
                end

                ST_LOW: begin
                    if (w_low_done) begin
                        // Period boundary: the only place a running divider
                        // picks up a new ratio or honours en going low.
                        r_cnt <= '0;
                        if (en) begin
                            r_state   <= ST_HIGH;
                            r_ratio   <= w_eff_ratio;
                            r_clk_out <= 1'b1;
                            r_tick    <= 1'b1;
                            r_active  <= 1'b1;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_clk_out <= 1'b0;
                            r_tick    <= 1'b0;
                            r_active  <= 1'b0;
                        end
                    end else begin
                        r_cnt     <= r_cnt + DIV_WIDTH'(1);
                        r_clk_out <= 1'b0;
                        r_tick    <= 1'b0;
                        r_active  <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_clk_out <= 1'b0;
                    r_tick    <= 1'b0;
                    r_active  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign active  = r_active;

endmodule

// File: tb/tb_clock_divider_prog.sv
// ---------------------------------------------------------------------------
// tb_clock_divider_prog
//   Directed bench for clock_divider_prog. A reference model expands each
//   period into a queue of clk_out levels (floor(N/2) ones then the rest
//   zeros) and pops one per clk_in edge; a negedge process compares the DUT
//   to it every cycle. Directed scenarios add literal phase-length and
//   output checks.
// ---------------------------------------------------------------------------
module tb_clock_divider_prog;

    localparam int DW = 8;

    logic          clk_in;
    logic          rst;
    logic          en;
    logic [DW-1:0] div_ratio;
    logic          clk_out;
    logic          tick;
    logic          active;

    int n_checks = 0;
    int n_fail   = 0;

    clock_divider_prog #(
        .DIV_WIDTH    (DW),
        .DEFAULT_RATIO(2)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .div_ratio(div_ratio),
        .clk_out  (clk_out),
        .tick     (tick),
        .active   (active)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    bit q[$];
    bit m_valid = 1'b0;
    bit m_clk   = 1'b0;
    bit m_tick  = 1'b0;
    bit m_act   = 1'b0;

    always @(posedge clk_in) begin
        int n;
        if (rst) begin
            q.delete();
            m_clk   = 1'b0;
            m_tick  = 1'b0;
            m_act   = 1'b0;
            m_valid = 1'b1;
        end else if (q.size() == 0) begin
            if (en) begin
                n = (int'(div_ratio) < 2) ? 2 : int'(div_ratio);
                for (int i = 0; i < n; i++) q.push_back(i < n / 2);
                m_clk  = q.pop_front();
                m_tick = 1'b1;
                m_act  = 1'b1;
            end else begin
                m_clk  = 1'b0;
                m_tick = 1'b0;
                m_act  = 1'b0;
            end
        end else begin
            m_clk  = q.pop_front();
            m_tick = 1'b0;
            m_act  = 1'b1;
        end
    end

    always @(negedge clk_in) begin
        if (m_valid) begin
            n_checks += 3;
            if (clk_out !== m_clk) begin
                n_fail++;
                $display("FAIL model_clk_out t=%0t got %b expected %b", $time, clk_out, m_clk);
            end
            if (tick !== m_tick) begin
                n_fail++;
                $display("FAIL model_tick t=%0t got %b expected %b", $time, tick, m_tick);
            end
            if (active !== m_act) begin
                n_fail++;
                $display("FAIL model_active t=%0t got %b expected %b", $time, active, m_act);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Measures one period from a tick cycle to the next tick. Optionally
    // rewrites div_ratio chg_at cycles into the period.
    task automatic measure(input int chg_at, input logic [DW-1:0] chg_val,
                           output int hi, output int lo);
        int guard;
        hi = 0;
        lo = 0;
        guard = 0;
        while (tick !== 1'b1 && guard < 1000) begin
            @(negedge clk_in);
            guard++;
        end
        if (guard >= 1000) begin
            check("measure_start_timeout", guard, 0);
            return;
        end
        guard = 0;
        do begin
            if (clk_out === 1'b1) hi++;
            else lo++;
            @(negedge clk_in);
            guard++;
            if (guard == chg_at) div_ratio = chg_val;
        end while (tick !== 1'b1 && guard < 1000);
        if (guard >= 1000) check("measure_end_timeout", guard, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hi, lo, cnt;

        rst       = 1'b1;
        en        = 1'b1;
        div_ratio = 8'd2;
        cyc(3);
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_active", int'(active), 0);
        rst = 1'b0;
        cyc(1);
        check("start_clk_out", int'(clk_out), 1);
        check("start_tick", int'(tick), 1);
        check("start_active", int'(active), 1);

        // ratio 2
        measure(-1, '0, hi, lo);
        check("r2_high", hi, 1);
        check("r2_low", lo, 1);
        measure(-1, '0, hi, lo);
        check("r2_period", hi + lo, 2);

        // ratio 5: odd ratio puts the extra cycle in the low phase
        div_ratio = 8'd5;
        measure(-1, '0, hi, lo);
        measure(-1, '0, hi, lo);
        check("r5_high", hi, 2);
        check("r5_low", lo, 3);

        // ratios 0 and 1 behave as 2
        div_ratio = 8'd0;
        measure(-1, '0, hi, lo);
        measure(-1, '0, hi, lo);
        check("r0_high", hi, 1);
        check("r0_low", lo, 1);
        div_ratio = 8'd1;
        measure(-1, '0, hi, lo);
        measure(-1, '0, hi, lo);
        check("r1_high", hi, 1);
        check("r1_low", lo, 1);

        // ratio 4, change to 6 inside the high phase
        div_ratio = 8'd4;
        measure(-1, '0, hi, lo);
        measure(1, 8'd6, hi, lo);
        check("r4_keep_high", hi, 2);
        check("r4_keep_low", lo, 2);
        measure(-1, '0, hi, lo);
        check("r6_high", hi, 3);
        check("r6_low", lo, 3);

        // ratio 8, drop en during high: full period then idle
        div_ratio = 8'd8;
        measure(-1, '0, hi, lo);
        hi = 0;
        lo = 0;
        for (int i = 0; i < 20; i++) begin
            if (active === 1'b1) begin
                if (clk_out === 1'b1) hi++;
                else lo++;
            end
            if (i == 1) en = 1'b0;
            @(negedge clk_in);
        end
        check("r8_stop_high", hi, 4);
        check("r8_stop_low", lo, 4);
        check("r8_idle_active", int'(active), 0);
        check("r8_idle_clk_out", int'(clk_out), 0);
        en = 1'b1;
        cyc(1);
        check("r8_restart_clk_out", int'(clk_out), 1);
        check("r8_restart_tick", int'(tick), 1);

        // ratio 10, reset mid-low, restart at ratio 3
        div_ratio = 8'd10;
        measure(-1, '0, hi, lo);
        cyc(7);
        check("r10_in_low", int'(clk_out), 0);
        rst       = 1'b1;
        div_ratio = 8'd3;
        cyc(1);
        check("midreset_clk_out", int'(clk_out), 0);
        check("midreset_active", int'(active), 0);
        check("midreset_tick", int'(tick), 0);
        rst = 1'b0;
        measure(-1, '0, hi, lo);
        check("r3_high", hi, 1);
        check("r3_low", lo, 2);

        // ratio 255: longest phases, no counter wrap
        div_ratio = 8'd255;
        measure(-1, '0, hi, lo);
        measure(-1, '0, hi, lo);
        check("r255_high", hi, 127);
        check("r255_low", lo, 128);
        cnt = 0;
        for (int i = 0; i < 4 * 255; i++) begin
            if (tick === 1'b1) cnt++;
            @(negedge clk_in);
        end
        check("r255_ticks_4_periods", cnt, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
